// File: rtl/mac_header_parser.sv
// Ingress header parser: captures DA/SA, folds them to MAC-table indices, issues lookup/learn
// and registers the returned egress port. Optional stats counters under MAC_PARSER_STATS_EN.
module mac_header_parser #(
    parameter int  pPORT_NUM = 4,
    parameter int  pSLOTS    = 256,
    localparam int PW        = $clog2(pPORT_NUM),
    localparam int IW        = $clog2(pSLOTS)
) (
    input  logic          iclk,
    input  logic          i_reset,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    input  logic          i_sof,
    input  logic          i_eof,
    output logic          o_ready,
    input  logic [PW-1:0] i_port_num,
    output logic          o_write_enable,
    output logic [PW-1:0] o_port_num,
    output logic [IW-1:0] o_MAC_SA,
    output logic [IW-1:0] o_MAC_DA,
    input  logic [PW-1:0] i_table_port,
    output logic          o_dst_valid,
    output logic [PW-1:0] o_dst_port,
    output logic          o_flood,
`ifdef MAC_PARSER_STATS_EN
    output logic [31:0]   o_frame_cnt,
    output logic [15:0]   o_runt_cnt,
    output logic [31:0]   o_learn_cnt,
`endif
    output logic          o_runt
);

    typedef enum logic [2:0] {
        S_IDLE, S_DA, S_SA, S_ISSUE, S_WAIT, S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [47:0]   da_q, da_d;
    logic [47:0]   sa_q, sa_d;
    logic          eof_q, eof_d;
    logic          runt_q, runt_d;
    logic          dst_valid_q, dst_valid_d;
    logic [PW-1:0] dst_port_q, dst_port_d;
    logic          flood_q, flood_d;
    logic [IW-1:0] mac_da_q, mac_da_d;
    logic [IW-1:0] mac_sa_q, mac_sa_d;
    logic [PW-1:0] port_q, port_d;

    logic          acc;
    logic          in_issue;
    logic [IW-1:0] fold_da;
    logic [IW-1:0] fold_sa;

    // Bit b of the MAC lands on bit (b mod IW): same as XOR of zero-padded IW-bit chunks.
    function automatic logic [IW-1:0] fold(input logic [47:0] mac);
        logic [IW-1:0] r;
        r = '0;
        for (int b = 0; b < 48; b++) begin
            r[b % IW] = r[b % IW] ^ mac[b];
        end
        return r;
    endfunction

    assign fold_da  = fold(da_q);
    assign fold_sa  = fold(sa_q);
    assign in_issue = (state_q == S_ISSUE);
    assign o_ready  = !(state_q == S_ISSUE || state_q == S_WAIT);
    assign acc      = i_valid && o_ready;

    assign o_write_enable = in_issue && !sa_q[40];
    assign o_MAC_DA       = in_issue ? fold_da : mac_da_q;
    assign o_MAC_SA       = in_issue ? fold_sa : mac_sa_q;
    assign o_port_num     = in_issue ? i_port_num : port_q;
    assign o_dst_valid    = dst_valid_q;
    assign o_dst_port     = dst_port_q;
    assign o_flood        = flood_q;
    assign o_runt         = runt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        da_d        = da_q;
        sa_d        = sa_q;
        eof_d       = eof_q;
        runt_d      = 1'b0;
        dst_valid_d = 1'b0;
        dst_port_d  = dst_port_q;
        flood_d     = flood_q;
        mac_da_d    = mac_da_q;
        mac_sa_d    = mac_sa_q;
        port_d      = port_q;

        case (state_q)
            S_IDLE, S_DA, S_SA, S_DRAIN: begin
                if (acc && i_sof) begin
                    // An sof mid-header aborts the partial frame; in DRAIN it just closes it.
                    runt_d = (state_q == S_DA || state_q == S_SA) || i_eof;
                    da_d   = {40'b0, i_data};
                    if (i_eof) begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = S_DA;
                        cnt_d   = 4'd1;
                    end
                end else if (acc && state_q == S_DRAIN) begin
                    if (i_eof) state_d = S_IDLE;
                end else if (acc && (state_q == S_DA || state_q == S_SA)) begin
                    if (i_eof && !(state_q == S_SA && cnt_q == 4'd11)) begin
                        runt_d  = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end else if (state_q == S_DA) begin
                        da_d  = {da_q[39:0], i_data};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd5) state_d = S_SA;
                    end else begin
                        sa_d  = {sa_q[39:0], i_data};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd11) begin
                            state_d = S_ISSUE;
                            eof_d   = i_eof;
                        end
                    end
                end
            end
            S_ISSUE: begin
                mac_da_d = fold_da;
                mac_sa_d = fold_sa;
                port_d   = i_port_num;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                dst_valid_d = 1'b1;
                dst_port_d  = i_table_port;
                flood_d     = da_q[40];
                cnt_d       = 4'd0;
                state_d     = eof_q ? S_IDLE : S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            da_q        <= '0;
            sa_q        <= '0;
            eof_q       <= 1'b0;
            runt_q      <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_port_q  <= '0;
            flood_q     <= 1'b0;
            mac_da_q    <= '0;
            mac_sa_q    <= '0;
            port_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            da_q        <= da_d;
            sa_q        <= sa_d;
            eof_q       <= eof_d;
            runt_q      <= runt_d;
            dst_valid_q <= dst_valid_d;
            dst_port_q  <= dst_port_d;
            flood_q     <= flood_d;
            mac_da_q    <= mac_da_d;
            mac_sa_q    <= mac_sa_d;
            port_q      <= port_d;
        end
    end

`ifdef MAC_PARSER_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] runt_cnt_q;
    logic [31:0] learn_cnt_q;

    always_ff @(posedge iclk) begin
        if (i_reset) begin
            frame_cnt_q <= '0;
            runt_cnt_q  <= '0;
            learn_cnt_q <= '0;
        end else begin
            if (in_issue)       frame_cnt_q <= frame_cnt_q + 32'd1;
            if (runt_q)         runt_cnt_q  <= runt_cnt_q + 16'd1;
            if (o_write_enable) learn_cnt_q <= learn_cnt_q + 32'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_runt_cnt  = runt_cnt_q;
    assign o_learn_cnt = learn_cnt_q;
`endif

endmodule

// File: tb/tb_mac_header_parser.sv
// Directed bench for mac_header_parser: frames driven byte by byte, outputs sampled on negedge.
module tb_mac_header_parser;

    logic       iclk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_data = '0;
    logic       i_valid = 1'b0, i_sof = 1'b0, i_eof = 1'b0;
    logic       o_ready;
    logic [1:0] i_port_num = '0;
    logic       o_write_enable;
    logic [1:0] o_port_num;
    logic [7:0] o_MAC_SA, o_MAC_DA;
    logic [1:0] i_table_port = '0;
    logic       o_dst_valid;
    logic [1:0] o_dst_port;
    logic       o_flood, o_runt;
`ifdef MAC_PARSER_STATS_EN
    logic [31:0] o_frame_cnt, o_learn_cnt;
    logic [15:0] o_runt_cnt;
`endif

    mac_header_parser dut (
        .iclk(iclk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .i_sof(i_sof), .i_eof(i_eof), .o_ready(o_ready), .i_port_num(i_port_num),
        .o_write_enable(o_write_enable), .o_port_num(o_port_num), .o_MAC_SA(o_MAC_SA),
        .o_MAC_DA(o_MAC_DA), .i_table_port(i_table_port), .o_dst_valid(o_dst_valid),
        .o_dst_port(o_dst_port), .o_flood(o_flood),
`ifdef MAC_PARSER_STATS_EN
        .o_frame_cnt(o_frame_cnt), .o_runt_cnt(o_runt_cnt), .o_learn_cnt(o_learn_cnt),
`endif
        .o_runt(o_runt)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    int lk_n = 0, we_n = 0, dv_n = 0, runt_n = 0, rdy_low_n = 0;
    int lk_cyc = 0, dv_cyc = 0, acc_cyc = 0;
    logic [7:0] lk_da = '0, lk_sa = '0;
    logic       lk_we = 1'b0, dv_flood = 1'b0, prev_rdy = 1'b1;
    logic [1:0] lk_port = '0, dv_port = '0;
    int l0, w0, d0, r0, q0;

    // Event log: a lookup is the first cycle of an o_ready-low window.
    always @(negedge iclk) begin
        if (!o_ready && prev_rdy) begin
            lk_n++; lk_cyc = cyc; lk_da = o_MAC_DA; lk_sa = o_MAC_SA;
            lk_we = o_write_enable; lk_port = o_port_num;
        end
        if (!o_ready) rdy_low_n++;
        if (o_write_enable) we_n++;
        if (o_dst_valid) begin
            dv_n++; dv_cyc = cyc; dv_port = o_dst_port; dv_flood = o_flood;
        end
        if (o_runt) runt_n++;
        prev_rdy = o_ready;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int w;
        w = 0;
        i_valid = 1'b1; i_data = d; i_sof = s; i_eof = e;
        while (!o_ready && w < 20) begin
            @(negedge iclk);
            w++;
        end
        if (w >= 20) check("ready_timeout", 1, 0);
        acc_cyc = cyc;
        @(negedge iclk);
        i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] da, input logic [47:0] sa, input int len,
                              input bit eof_last, output int c0, output int c11);
        logic [95:0] hdr;
        logic [7:0]  b;
        hdr = {da, sa};
        c0 = 0; c11 = 0;
        for (int i = 0; i < len; i++) begin
            b = (i < 12) ? hdr[95-8*i -: 8] : 8'(i);
            send(b, i == 0, eof_last && (i == len - 1));
            if (i == 0)  c0  = acc_cyc;
            if (i == 11) c11 = acc_cyc;
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge iclk);
        #1;
    endtask

    task automatic snap();
        l0 = lk_n; w0 = we_n; d0 = dv_n; r0 = runt_n; q0 = rdy_low_n;
    endtask

    int c0, n, c0b, nb;

    initial begin
        repeat (3) @(negedge iclk);
        check("rst_ready", o_ready, 1);
        check("rst_we", o_write_enable, 0);
        check("rst_da", o_MAC_DA, 0);
        check("rst_sa", o_MAC_SA, 0);
        check("rst_port", o_port_num, 0);
        check("rst_dv", o_dst_valid, 0);
        check("rst_dport", o_dst_port, 0);
        check("rst_flood", o_flood, 0);
        check("rst_runt", o_runt, 0);
        i_reset = 1'b0;
        @(negedge iclk);

        // 1: 64-byte unicast frame
        i_port_num = 2'd2; i_table_port = 2'd3;
        snap();
        send_frame(48'h0011_2233_4455, 48'h0200_0000_0007, 64, 1, c0, n);
        settle();
        check("t1_lk_n", lk_n - l0, 1);
        check("t1_lk_cyc", lk_cyc, n + 1);
        check("t1_da", lk_da, 8'h11);
        check("t1_sa", lk_sa, 8'h05);
        check("t1_we", lk_we, 1);
        check("t1_port", lk_port, 2);
        check("t1_dv_n", dv_n - d0, 1);
        check("t1_dv_cyc", dv_cyc, n + 3);
        check("t1_dport", dv_port, 3);
        check("t1_flood", dv_flood, 0);
        check("t1_rdy_low", rdy_low_n - q0, 2);
        check("t1_hold_da", o_MAC_DA, 8'h11);

        // 2: broadcast DA, multicast SA -> no learn, flood
        i_table_port = 2'd1;
        snap();
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0100_5E00_0001, 14, 1, c0, n);
        settle();
        check("t2_lk_n", lk_n - l0, 1);
        check("t2_da", lk_da, 8'h00);
        check("t2_sa", lk_sa, 8'h5E);
        check("t2_we", we_n - w0, 0);
        check("t2_flood", dv_flood, 1);
        check("t2_dport", dv_port, 1);

        // 3: eof on byte 7 -> runt, then a good frame
        snap();
        send_frame(48'h0011_2233_4455, 48'h0200_0000_0007, 8, 1, c0, n);
        settle();
        check("t3_runt", runt_n - r0, 1);
        check("t3_lk_n", lk_n - l0, 0);
        check("t3_we", we_n - w0, 0);
        check("t3_dv", dv_n - d0, 0);
        i_port_num = 2'd1; i_table_port = 2'd2;
        snap();
        send_frame(48'h1020_3040_5060, 48'h0000_0000_00AB, 20, 1, c0, n);
        settle();
        check("t3b_lk_n", lk_n - l0, 1);
        check("t3b_da", lk_da, 8'h70);
        check("t3b_sa", lk_sa, 8'hAB);
        check("t3b_port", lk_port, 1);
        check("t3b_dport", dv_port, 2);

        // 4: sof on byte 4 restarts capture
        snap();
        send_frame(48'h0011_2233_4455, 48'h0, 4, 0, c0, n);
        send_frame(48'hAABB_CCDD_EEF0, 48'h0400_0000_0001, 12, 1, c0, n);
        settle();
        check("t4_runt", runt_n - r0, 1);
        check("t4_lk_n", lk_n - l0, 1);
        check("t4_da", lk_da, 8'h1E);
        check("t4_sa", lk_sa, 8'h05);
        check("t4_we", we_n - w0, 1);

        // 5: exact 12-byte frame, next sof held back by o_ready
        snap();
        send_frame(48'h0000_0000_0001, 48'h0000_0000_0002, 12, 1, c0, n);
        send_frame(48'h0000_0000_0003, 48'h0000_0000_0004, 12, 1, c0b, nb);
        settle();
        check("t5_held_acc", c0b, n + 3);
        check("t5_lk_n", lk_n - l0, 2);
        check("t5_dv_n", dv_n - d0, 2);
        check("t5_da", lk_da, 8'h03);
        check("t5_runt", runt_n - r0, 0);

        // 7: sof while draining closes the old frame silently
        snap();
        send_frame(48'h0000_0000_0005, 48'h0000_0000_0006, 16, 0, c0, n);
        send_frame(48'h0000_0000_0007, 48'h0000_0000_0008, 12, 1, c0, n);
        settle();
        check("t7_lk_n", lk_n - l0, 2);
        check("t7_runt", runt_n - r0, 0);
        check("t7_da", lk_da, 8'h07);

`ifdef MAC_PARSER_STATS_EN
        check("st_frames", o_frame_cnt, lk_n);
        check("st_learn", o_learn_cnt, we_n);
        check("st_runt", o_runt_cnt, runt_n);
`endif

        // 6: reset while in WAIT
        snap();
        send_frame(48'h0011_2233_4455, 48'h0200_0000_0007, 12, 0, c0, n);
        @(negedge iclk);
        i_reset = 1'b1;
        @(negedge iclk);
        check("t6_dv", o_dst_valid, 0);
        check("t6_ready", o_ready, 1);
        check("t6_da", o_MAC_DA, 0);
        check("t6_sa", o_MAC_SA, 0);
        check("t6_port", o_port_num, 0);
        check("t6_dport", o_dst_port, 0);
`ifdef MAC_PARSER_STATS_EN
        check("t6_st_frames", o_frame_cnt, 0);
        check("t6_st_learn", o_learn_cnt, 0);
        check("t6_st_runt", o_runt_cnt, 0);
`endif
        i_reset = 1'b0;
        settle();
        check("t6_dv_n", dv_n - d0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
